// File: rtl/nanosoc_arbiter_param.sv
`default_nettype none
//============================================================================
// Module   : nanosoc_arbiter_param
// Purpose  : Output-stage arbiter for the nanosoc AHB bus matrix. Selects
//            which of NUM_PORTS input stages drives the shared slave port.
//            Holds the grant across locked transfers and fixed-length
//            bursts. Limits how many back-to-back early-terminated bursts
//            may keep burst hold. Selection is fixed priority (port 0
//            highest) or round-robin.
// Macro    : NANOSOC_ARB_ROUND_ROBIN_EN - compiles in the round-robin
//            search. Without it only fixed priority exists, and
//            ARB_MODE=1 is an elaboration error.
// Ports    : HCLK, HRESETn (async, active-low)
//            req_port[NUM_PORTS] - per-port request lines
//            HREADYM             - qualifies every register update
//            HSELM, HTRANSM, HBURSTM, HMASTLOCKM - current output addr phase
//            addr_in_port[PORT_W] - registered granted port index
//            no_port              - registered, 1 = no port selected
// Revision : 1.0 - initial release
//============================================================================
module nanosoc_arbiter_param #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2,
    parameter int ARB_MODE  = 0,
    parameter int ETERM_MAX = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    localparam logic [1:0] c_TRN_IDLE   = 2'b00;
    localparam logic [1:0] c_TRN_BUSY   = 2'b01;
    localparam logic [1:0] c_TRN_NONSEQ = 2'b10;
    localparam logic [1:0] c_TRN_SEQ    = 2'b11;

    localparam logic [2:0] c_BST_WRAP4  = 3'b010;
    localparam logic [2:0] c_BST_INCR4  = 3'b011;
    localparam logic [2:0] c_BST_WRAP8  = 3'b100;
    localparam logic [2:0] c_BST_INCR8  = 3'b101;
    localparam logic [2:0] c_BST_WRAP16 = 3'b110;
    localparam logic [2:0] c_BST_INCR16 = 3'b111;

    localparam logic [2:0]           c_ETERM_MAX = 3'(ETERM_MAX);
    localparam logic [NUM_PORTS-1:0] c_PORT_ONE  = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    // Elaboration-time parameter checks
    if (PORT_W != $clog2(NUM_PORTS)) begin : g_bad_port_w
        $error("nanosoc_arbiter_param: PORT_W must equal $clog2(NUM_PORTS)");
    end
    if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
        $error("nanosoc_arbiter_param: NUM_PORTS must be in 2..16");
    end
    if (ETERM_MAX < 1 || ETERM_MAX > 7) begin : g_bad_eterm
        $error("nanosoc_arbiter_param: ETERM_MAX must be in 1..7");
    end

    // Lowest set index of a request vector (fixed priority, port 0 wins)
    function automatic logic [PORT_W-1:0] f_lowest(input logic [NUM_PORTS-1:0] vec);
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = PORT_W'(i);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Burst tracker
    // ------------------------------------------------------------------
    logic [3:0] r_burst_cnt;
    logic       r_burst_hold;
    logic [2:0] r_eterm_cnt;

    logic [3:0] w_cnt_nxt;
    logic       w_hold_nxt;
    logic [2:0] w_eterm_nxt;

    always_comb begin
        w_cnt_nxt  = r_burst_cnt;
        w_hold_nxt = r_burst_hold;
        if (!HSELM) begin
            w_cnt_nxt  = 4'd0;
            w_hold_nxt = 1'b0;
        end else begin
            case (HTRANSM)
                c_TRN_NONSEQ: begin
                    w_cnt_nxt  = 4'd0;
                    w_hold_nxt = 1'b0;
                    // Too many early terminations in a row: a new burst no
                    // longer locks out other requesters.
                    if (r_eterm_cnt != c_ETERM_MAX) begin
                        case (HBURSTM)
                            c_BST_WRAP16, c_BST_INCR16: begin
                                w_cnt_nxt  = 4'd15;
                                w_hold_nxt = 1'b1;
                            end
                            c_BST_WRAP8, c_BST_INCR8: begin
                                w_cnt_nxt  = 4'd7;
                                w_hold_nxt = 1'b1;
                            end
                            c_BST_WRAP4, c_BST_INCR4: begin
                                w_cnt_nxt  = 4'd3;
                                w_hold_nxt = 1'b1;
                            end
                            default: begin
                                w_cnt_nxt  = 4'd0;
                                w_hold_nxt = 1'b0;
                            end
                        endcase
                    end
                end
                c_TRN_SEQ: begin
                    w_cnt_nxt = r_burst_cnt - 4'd1;
                    if (r_burst_cnt == 4'd1) begin
                        w_hold_nxt = 1'b0;
                    end
                end
                c_TRN_BUSY: begin
                    w_cnt_nxt  = r_burst_cnt;
                    w_hold_nxt = r_burst_hold;
                end
                default: begin
                    w_cnt_nxt  = 4'd0;
                    w_hold_nxt = 1'b0;
                end
            endcase
        end
    end

    // A NONSEQ arriving while a burst is still held is an early termination.
    always_comb begin
        w_eterm_nxt = r_eterm_cnt;
        if (!w_hold_nxt) begin
            w_eterm_nxt = 3'd0;
        end else if (r_burst_hold && (HTRANSM == c_TRN_NONSEQ) &&
                     (r_eterm_cnt != c_ETERM_MAX)) begin
            w_eterm_nxt = r_eterm_cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Port selection
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] w_cur_oh;
    logic                 w_cur_live;
    logic [NUM_PORTS-1:0] w_cand;
    logic [PORT_W-1:0]    w_pick;
    logic [PORT_W-1:0]    w_addr_nxt;
    logic                 w_nop_nxt;

    // The current owner stays a candidate while its transfer is active.
    assign w_cur_oh   = c_PORT_ONE << addr_in_port;
    assign w_cur_live = HSELM && (HTRANSM != c_TRN_IDLE);
    assign w_cand     = req_port | (w_cur_oh & {NUM_PORTS{w_cur_live}});

`ifdef NANOSOC_ARB_ROUND_ROBIN_EN
    if (ARB_MODE == 1) begin : g_rr
        logic [PORT_W-1:0] w_rr_idx;
        logic [PORT_W-1:0] w_rr_pos;
        logic              w_rr_found;

        // Search upward from the port after the current owner, so the
        // owner itself is examined last.
        always_comb begin
            w_rr_idx   = addr_in_port;
            w_rr_pos   = addr_in_port;
            w_rr_found = 1'b0;
            for (int k = 1; k <= NUM_PORTS; k++) begin
                w_rr_pos = PORT_W'((int'(addr_in_port) + k) % NUM_PORTS);
                if (!w_rr_found && w_cand[w_rr_pos]) begin
                    w_rr_found = 1'b1;
                    w_rr_idx   = w_rr_pos;
                end
            end
        end
        assign w_pick = w_rr_idx;
    end else begin : g_fp
        assign w_pick = f_lowest(w_cand);
    end
`else
    if (ARB_MODE != 0) begin : g_rr_illegal
        $error("nanosoc_arbiter_param: ARB_MODE=1 needs NANOSOC_ARB_ROUND_ROBIN_EN");
    end
    if (1) begin : g_fp
        assign w_pick = f_lowest(w_cand);
    end
`endif

    always_comb begin
        w_addr_nxt = addr_in_port;
        w_nop_nxt  = 1'b0;
        if (!(HMASTLOCKM || w_hold_nxt)) begin
            if (|w_cand) begin
                w_addr_nxt = w_pick;
            end else if (!HSELM) begin
                // Nobody wants the port: flag it, but remember the old index.
                w_nop_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers - all frozen while HREADYM is low
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_burst_cnt  <= 4'd0;
            r_burst_hold <= 1'b0;
            r_eterm_cnt  <= 3'd0;
            addr_in_port <= '0;
            no_port      <= 1'b1;
        end else if (HREADYM) begin
            r_burst_cnt  <= w_cnt_nxt;
            r_burst_hold <= w_hold_nxt;
            r_eterm_cnt  <= w_eterm_nxt;
            addr_in_port <= w_addr_nxt;
            no_port      <= w_nop_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nanosoc_arbiter_param.sv
`default_nettype none
//============================================================================
// Module   : tb_nanosoc_arbiter_param
// Purpose  : Self-checking bench for nanosoc_arbiter_param. Directed
//            scenarios followed by random traffic, compared every cycle
//            against a behavioural model of the arbitration rules. The
//            arbitration mode follows NANOSOC_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
//============================================================================
module tb_nanosoc_arbiter_param;

    localparam int NP = 4;
    localparam int PW = 2;
    localparam int EM = 2;
`ifdef NANOSOC_ARB_ROUND_ROBIN_EN
    localparam int MODE = 1;
`else
    localparam int MODE = 0;
`endif

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;

    logic          HCLK;
    logic          HRESETn;
    logic [NP-1:0] req_port;
    logic          HREADYM;
    logic          HSELM;
    logic [1:0]    HTRANSM;
    logic [2:0]    HBURSTM;
    logic          HMASTLOCKM;
    logic [PW-1:0] addr_in_port;
    logic          no_port;

    nanosoc_arbiter_param #(
        .NUM_PORTS (NP),
        .PORT_W    (PW),
        .ARB_MODE  (MODE),
        .ETERM_MAX (EM)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: beats left in the held burst, whether the grant
    // is held, early-termination run length, and the grant itself.
    int m_left;
    bit m_hold;
    int m_eterm;
    int m_addr;
    bit m_nop;

    task automatic model_reset();
        m_left = 0; m_hold = 0; m_eterm = 0; m_addr = 0; m_nop = 1;
    endtask

    function automatic int burst_beats(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_step();
        int beats;
        int left_n;
        bit hold_n;
        int eterm_n;
        int cand;
        int pick;
        int p;
        beats   = burst_beats(HBURSTM);
        left_n  = m_left;
        hold_n  = m_hold;
        eterm_n = m_eterm;
        if (!HSELM) begin
            left_n = 0; hold_n = 0;
        end else if (HTRANSM == T_NSEQ) begin
            if (m_eterm == EM || beats == 1) begin
                left_n = 0; hold_n = 0;
            end else begin
                left_n = beats - 1; hold_n = 1;
            end
        end else if (HTRANSM == T_SEQ) begin
            left_n = (m_left + 15) % 16;
            if (m_left == 1) hold_n = 0;
        end else if (HTRANSM == T_IDLE) begin
            left_n = 0; hold_n = 0;
        end
        if (!hold_n)
            eterm_n = 0;
        else if (m_hold && HTRANSM == T_NSEQ)
            eterm_n = (m_eterm + 1 > EM) ? EM : m_eterm + 1;

        cand = int'(req_port);
        if (HSELM && HTRANSM != T_IDLE) cand = cand | (1 << m_addr);

        if (HMASTLOCKM || hold_n) begin
            m_nop = 0;
        end else if (cand != 0) begin
            pick = -1;
            for (int k = 0; k < NP; k++) begin
                p = MODE ? (m_addr + 1 + k) % NP : k;
                if (pick < 0 && ((cand >> p) & 1) == 1) pick = p;
            end
            m_addr = pick;
            m_nop  = 0;
        end else if (HSELM) begin
            m_nop = 0;
        end else begin
            m_nop = 1;
        end
        m_left = left_n; m_hold = hold_n; m_eterm = eterm_n;
    endtask

    task automatic check(input string tag);
        n_total++;
        assert (addr_in_port === PW'(m_addr)) n_pass++;
        else $error("FAIL %s: addr_in_port=%0d expected %0d", tag, addr_in_port, m_addr);
        n_total++;
        assert (no_port === m_nop) n_pass++;
        else $error("FAIL %s: no_port=%0b expected %0b", tag, no_port, m_nop);
    endtask

    task automatic set_in(input logic [NP-1:0] req, input logic sel, input logic [1:0] trn,
                          input logic [2:0] bst, input logic lock, input logic rdy);
        req_port = req; HSELM = sel; HTRANSM = trn; HBURSTM = bst;
        HMASTLOCKM = lock; HREADYM = rdy;
    endtask

    // One clock: model follows the edge the DUT sees, outputs checked mid-low phase.
    task automatic step(input string tag);
        @(posedge HCLK);
        if (HRESETn && HREADYM) model_step();
        @(negedge HCLK);
        check(tag);
    endtask

    initial begin
        HRESETn = 1'b0;
        set_in('0, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        model_reset();
        repeat (2) @(negedge HCLK);
        check("reset");
        HRESETn = 1'b1;

        // Idle, then a lone request from port 2
        step("idle");
        set_in(4'b0100, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        step("req2");

        // Port 3 INCR4; port 0 starts requesting on beat 2
        set_in(4'b1000, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        step("p3_grant");
        set_in(4'b1000, 1'b1, T_NSEQ, B_INCR4, 1'b0, 1'b1);
        step("incr4_nseq");
        set_in(4'b1001, 1'b1, T_SEQ, B_INCR4, 1'b0, 1'b1);
        repeat (3) step("incr4_seq");

        // Back-to-back early-terminated INCR8s from port 1, port 0 waiting
        set_in(4'b0010, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        step("p1_grant");
        set_in(4'b0011, 1'b1, T_NSEQ, B_INCR8, 1'b0, 1'b1);
        repeat (4) step("eterm_nseq");

        // All four requesting with SINGLE transfers
        set_in(4'b1111, 1'b1, T_NSEQ, B_SINGLE, 1'b0, 1'b1);
        repeat (5) step("single_all");

        // Locked port 2 with a 3-cycle stall
        set_in(4'b0100, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        step("p2_grant");
        set_in(4'b1111, 1'b1, T_NSEQ, B_SINGLE, 1'b1, 1'b1);
        step("lock");
        set_in(4'b1011, 1'b1, T_NSEQ, B_INCR16, 1'b0, 1'b0);
        repeat (3) step("stall");
        set_in(4'b1111, 1'b1, T_NSEQ, B_SINGLE, 1'b1, 1'b1);
        step("lock_resume");

        // Reset in the middle of an INCR16 (9 beats remaining)
        set_in(4'b0010, 1'b0, T_IDLE, B_SINGLE, 1'b0, 1'b1);
        step("p1_again");
        set_in(4'b0010, 1'b1, T_NSEQ, B_INCR16, 1'b0, 1'b1);
        step("incr16_nseq");
        set_in(4'b0011, 1'b1, T_SEQ, B_INCR16, 1'b0, 1'b1);
        repeat (6) step("incr16_seq");
        #2;
        HRESETn = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(negedge HCLK);
        HRESETn = 1'b1;
        set_in(4'b1000, 1'b1, T_NSEQ, B_INCR4, 1'b0, 1'b1);
        step("post_rst");

        // Random traffic
        repeat (500) begin
            set_in(NP'($urandom_range(0, 15) & ($urandom_range(0, 3) == 0 ? 0 : 15)),
                   $urandom_range(0, 9) != 0,
                   2'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)),
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) != 0);
            step("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
